// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth_table self-test sweeper.
//   sweep_state_t : sweeper FSM states
//   NUM_VECTORS   : number of {A,B,C,D} input combinations
//   TT_GOLDEN     : golden Y response, bit i = Y for {A,B,C,D} = i (A is MSB)
package tt_sweep_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } sweep_state_t;

   localparam int          NUM_VECTORS = 16;
   localparam logic [15:0] TT_GOLDEN   = 16'hFC55;

endpackage

// File: rtl/tt_settle_counter.sv
// Loadable down-counter with zero flag; times the settle window of each vector.
//   clk, reset_n : clock, async active-low reset
//   load         : load count with load_val (wins over dec)
//   load_val     : value to load
//   dec          : decrement while nonzero
//   count        : current count
//   zero         : count == 0
module tt_settle_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec && (count != '0))
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Self-test sequencer for the truth_table block: drives all 16 {A,B,C,D}
// combinations, waits SETTLE_CYCLES per vector, samples Y, compares to EXPECTED.
//   clk, reset_n : clock, async active-low reset
//   start        : request a sweep (accepted only in IDLE)
//   abort        : abandon a running sweep
//   y_in         : Y from the truth_table instance
//   abcd         : {A,B,C,D} drive to the truth_table instance
//   busy         : sweep in progress
//   done         : one-cycle pulse on sweep completion
//   pass         : last completed sweep had zero mismatches
//   err_count    : mismatches in current/last sweep
//   result       : captured Y per vector index
//   mismatch     : result ^ EXPECTED per vector index
module truth_table_sweeper
   import tt_sweep_pkg::*;
#(
   parameter int          SETTLE_CYCLES = 2,
   parameter logic [15:0] EXPECTED      = TT_GOLDEN
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   input  logic        y_in,
   output logic [3:0]  abcd,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [4:0]  err_count,
   output logic [15:0] result,
   output logic [15:0] mismatch
);

   // SETTLE exits when the counter reads zero, so load one less than the
   // number of cycles to spend there.
   localparam logic [3:0] SETTLE_LOAD =
      (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

   sweep_state_t state;
   logic [3:0]   index;
   logic [3:0]   settle_cnt;
   logic         settle_zero;
   logic         miss_bit;

   tt_settle_counter #(.W(4)) u_settle (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (state == ST_APPLY),
      .load_val (SETTLE_LOAD),
      .dec      (state == ST_SETTLE),
      .count    (settle_cnt),
      .zero     (settle_zero)
   );

   assign miss_bit = y_in ^ EXPECTED[index];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         index     <= '0;
         abcd      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         result    <= '0;
         mismatch  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  index     <= '0;
                  result    <= '0;
                  mismatch  <= '0;
                  err_count <= '0;
                  pass      <= 1'b0;
                  busy      <= 1'b1;
                  state     <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  abcd  <= index;
                  state <= (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else if (settle_zero) begin
                  state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               // abort drops this vector's sample; partial results stay visible
               if (abort) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  result[index]   <= y_in;
                  mismatch[index] <= miss_bit;
                  err_count       <= err_count + {4'd0, miss_bit};
                  if (index == 4'd15) begin
                     state <= ST_DONE;
                  end else begin
                     index <= index + 4'd1;
                     state <= ST_APPLY;
                  end
               end
            end
            ST_DONE: begin
               done  <= 1'b1;
               pass  <= (err_count == 5'd0);
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
